// File: rtl/regfile_write_queue_pkg.sv
// Shared widths, constants and the queue entry layout for the register-file
// write queue.
package regfile_write_queue_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Producer-side writeback offer: valid/ready handshake carrying a destination
// register and its result value.
interface regfile_write_queue_if;
  import regfile_write_queue_pkg::*;

  logic                  enq_valid;
  logic                  enq_ready;
  logic [REG_ADDR_W-1:0] enq_reg;
  logic [DATA_W-1:0]     enq_data;

  modport master (
    output enq_valid,
    output enq_reg,
    output enq_data,
    input  enq_ready
  );

  modport slave (
    input  enq_valid,
    input  enq_reg,
    input  enq_data,
    output enq_ready
  );

endinterface

// File: rtl/regfile_write_queue_wq_fifo_core.sv
// Circular FIFO storage for the write queue: pointers, occupancy, per-slot
// valid bits and a zero-gated view of the head entry.
module wq_fifo_core
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  wq_entry_t                      push_entry,
  input  logic                           pop,
  output wq_entry_t                      head_entry,
  output wq_entry_t                      entries [DEPTH],
  output logic [DEPTH-1:0]               valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wq_entry_t        mem_q [DEPTH];
  wq_entry_t        mem_d [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    mem_d    = mem_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      mem_q    <= mem_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
      assign entries[gi] = mem_q[gi];
    end
  endgenerate

  assign valid      = valid_q;
  assign count      = count_q;
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_entry = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_queue.sv
// Buffered register-file write initiator: queues long-latency writebacks and
// drains them into the write port in cycles the main pipeline leaves free.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_write_queue_if.slave         enq,
  input  logic                         main_wr,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [NUM_REGS-1:0]          pending,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  logic             accept;
  logic             push;
  wq_entry_t        push_entry;
  wq_entry_t        head_entry;
  wq_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [NUM_REGS-1:0] entry_mask [DEPTH];

  // Writes to $zero complete the handshake but are never stored.
  assign enq.enq_ready = !full;
  assign accept        = enq.enq_valid && enq.enq_ready;
  assign push          = accept && (enq.enq_reg != REG_ZERO);
  assign push_entry    = '{waddr: enq.enq_reg, data: enq.enq_data};

  assign rf_we    = !empty && !main_wr;
  assign rf_waddr = head_entry.waddr;
  assign rf_wdata = head_entry.data;

  wq_fifo_core #(
    .DEPTH (DEPTH)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (rf_we),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
      assign entry_mask[gi] = valid[gi] ? (NUM_REGS'(1) << entries[gi].waddr) : '0;
    end
  endgenerate

  // Bit 0 is masked explicitly so decode never stalls on $zero.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending | entry_mask[i];
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed and randomized checks of regfile_write_queue against a queue-based
// reference model of the writeback buffer.
module tb_regfile_write_queue;
  import regfile_write_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                reset;
  logic                main_wr;
  logic                rf_we;
  logic [4:0]          rf_waddr;
  logic [31:0]         rf_wdata;
  logic [31:0]         pending;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;

  int checks = 0;
  int errors = 0;

  wq_entry_t model_q [$];

  regfile_write_queue_if enq_if ();

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .enq      (enq_if.slave),
    .main_wr  (main_wr),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .pending  (pending),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model queue contents and main_wr.
  task automatic check_all();
    logic [31:0] exp_pend;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    exp_pend = '0;
    foreach (model_q[i]) exp_pend[model_q[i].waddr] = 1'b1;
    exp_addr = (model_q.size() != 0) ? 32'(model_q[0].waddr) : 32'd0;
    exp_data = (model_q.size() != 0) ? model_q[0].data : 32'd0;
    check("count",     32'(count),            32'(model_q.size()));
    check("empty",     32'(empty),            32'(model_q.size() == 0));
    check("full",      32'(full),             32'(model_q.size() == DEPTH));
    check("enq_ready", 32'(enq_if.enq_ready), 32'(model_q.size() < DEPTH));
    check("rf_we",     32'(rf_we),            32'(model_q.size() != 0 && !main_wr));
    check("rf_waddr",  32'(rf_waddr),         exp_addr);
    check("rf_wdata",  rf_wdata,              exp_data);
    check("pending",   pending,               exp_pend);
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, then
  // advance the model with what the edge should have done.
  task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d, input logic mw);
    logic acc;
    logic we;
    @(negedge clk);
    enq_if.enq_valid = v;
    enq_if.enq_reg   = r;
    enq_if.enq_data  = d;
    main_wr          = mw;
    #1;
    check_all();
    acc = v && (model_q.size() < DEPTH);
    we  = (model_q.size() != 0) && !mw;
    @(posedge clk);
    if (we) begin
      $display("write r%0d <= 0x%08h", model_q[0].waddr, model_q[0].data);
      void'(model_q.pop_front());
    end
    if (acc && r != 5'd0) model_q.push_back('{waddr: r, data: d});
  endtask

  initial begin
    reset            = 1'b1;
    main_wr          = 1'b0;
    enq_if.enq_valid = 1'b0;
    enq_if.enq_reg   = '0;
    enq_if.enq_data  = '0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Single write, then observe it drain and the queue empty again.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Fill under stall, attempt an extra offer while full, then drain.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'(i * 'h11), 1'b1);
    cycle(1'b1, 5'd9, 32'h99, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Zero register is accepted and dropped.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Same register twice.
    cycle(1'b1, 5'd7, 32'hA, 1'b1);
    cycle(1'b1, 5'd7, 32'hB, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Concurrent enqueue and pop at count 2.
    cycle(1'b1, 5'd10, 32'h100, 1'b1);
    cycle(1'b1, 5'd11, 32'h101, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'(12 + i), 32'(32'h200 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 9) < 4));
    end

    // Asynchronous reset with three entries queued.
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'(20 + i), 32'(32'hC0 + i), 1'b1);
    @(negedge clk);
    enq_if.enq_valid = 1'b0;
    main_wr          = 1'b0;
    #1;
    check("pre_reset_count", 32'(count), 32'd3);
    reset = 1'b1;
    model_q.delete();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 5'd3, 32'h1234, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
